avmm_byte_channel: RTL and testbench
====================================

Name: avmm_byte_channel

Overview:
- Parametrised Avalon-MM byte channel: buffered bridge between the Nios data bus and a generic byte-stream link (host debug link, UART core or inter-FPGA serial).
- TX FIFO (CPU to link) and RX FIFO (link to CPU) with configurable depth and width.
- Programmable interrupt thresholds, sticky overflow flags, per-FIFO flush, and a selectable RX back-pressure or drop mode.
- Sits on the system interconnect as a 4-word slave; the link side is a valid/ready stream pair.

Parameters:
- DATA_W, 8, stream/FIFO data width (1..15).
- TX_AW, 6, log2 TX FIFO depth (TX_DEPTH = 2**TX_AW, 2..1024).
- RX_AW, 6, log2 RX FIFO depth (RX_DEPTH = 2**RX_AW, 2..1024).
- RX_DROP, 0, 0: rx_ready deasserts when RX is full; 1: rx_ready is tied to 1, bytes arriving while full are dropped and roverflow is set.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- av_address  in  2  word address: 0 DATA, 1 CONTROL, 2 THRESH, 3 STATUS
- av_chipselect  in  1  slave select
- av_read  in  1  read strobe, active-high
- av_write  in  1  write strobe, active-high
- av_writedata  in  32  write data
- av_readdata  out  32  registered read data
- av_waitrequest  out  1  stall
- av_irq  out  1  level interrupt
- tx_data  out  DATA_W  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  link accepts tx_data
- rx_data  in  DATA_W  incoming data
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data

Behaviour:
- Reset values:
  - av_waitrequest=1, av_readdata=0, av_irq=0, tx_valid=0.
  - rx_ready=1 (the RX FIFO is empty).
  - Both FIFOs empty; ie_rx=ie_tx=0; woverflow=roverflow=0.
  - rx_thresh=1; tx_thresh=TX_DEPTH/8 (minimum 1).
- Bus handshake:
  - A transfer is accepted in a cycle when chipselect & (read|write) & av_waitrequest.
  - In the next cycle av_waitrequest=0 and av_readdata is valid; the master completes in that cycle.
  - In the cycle after that, av_waitrequest returns to 1.
  - Every access therefore takes 2 cycles. Side effects happen once, in the accept cycle.
  - If read and write are both asserted, write wins.
- DATA write:
  - If TX is not full, push av_writedata[DATA_W-1:0]; otherwise set woverflow and discard.
- DATA read:
  - If RX is not empty, pop. Readdata bits:
    - [DATA_W-1:0] popped byte (0 if empty).
    - [15] rvalid = RX was non-empty.
    - [31:16] RX entry count after the pop.
- CONTROL:
  - Write fields:
    - [0] ie_rx, [1] ie_tx.
    - [2]=1 flushes TX and [3]=1 flushes RX (both self-clearing).
    - [10]=1 clears woverflow; [11]=1 clears roverflow.
  - Read fields:
    - [0] ie_rx, [1] ie_tx.
    - [8] ip_rx, [9] ip_tx.
    - [10] woverflow, [11] roverflow.
    - [31:16] TX free entries.
- THRESH:
  - [15:0] rx_thresh; [31:16] tx_thresh. Values are truncated to RX_AW+1 and TX_AW+1 bits respectively.
  - Readback returns the truncated values.
- STATUS read:
  - [15:0] rx_used, [31:16] tx_used, zero-extended.
  - Writes to STATUS are ignored.
- Interrupt:
  - ip_rx = ie_rx & (rx_used >= rx_thresh) & (rx_used != 0).
  - ip_tx = ie_tx & (tx_used <= tx_thresh).
  - av_irq is registered: av_irq = ip_rx | ip_tx, delayed by 1 cycle.
- FIFOs:
  - Circular buffers with AW-bit pointers that wrap modulo depth, and an (AW+1)-bit count so full (count=DEPTH) and empty are distinguishable.
  - tx_data/tx_valid are first-word fall-through from the head.
  - A TX pop happens when tx_valid & tx_ready. An RX push happens when rx_valid & rx_ready (RX_DROP=0), or when rx_valid & not full (RX_DROP=1).
- Simultaneous push and pop on one FIFO:
  - The count is unchanged, and both operations take effect.
  - Full is evaluated on the pre-cycle count, so a push while full is rejected even if a pop occurs in the same cycle.
  - A pop on empty has no effect.
- rx_ready (RX_DROP=0) is combinational: rx_ready = ~rx_full.
- With RX_DROP=1, rx_valid while full sets roverflow and drops the byte.
- Flush:
  - Resets the pointers and count in the accept cycle. A concurrent push or pop in that cycle is discarded.
  - Thresholds and flags are unchanged.
- Overflow flags are sticky: a set event in the same cycle as a clear wins.
- Asynchronous reset mid-transfer aborts the transfer: FIFO contents are lost and outputs return to their reset values immediately.

Test Plan:
- Reset, then read STATUS -> 0x00000000. Read CONTROL -> [31:16]=64, flags 0. Read THRESH -> 0x00080001. av_irq=0.
- Write DATA 0x41, 0x42 with tx_ready=0 -> tx_valid=1, tx_data=0x41. STATUS[31:16]=2. Raise tx_ready for 2 cycles -> 0x41 then 0x42 leave the block, tx_valid=0.
- With tx_ready=0, write 65 bytes -> first 64 are stored. CONTROL[10]=1 and [31:16]=0. Write CONTROL 0x400 -> woverflow cleared.
- RX_DROP=0: drive 64 bytes, then a 65th -> rx_ready=0 and rx_valid is held. Read DATA -> byte0 returned, [15]=1, [31:16]=63. Next cycle the 65th byte is accepted.
- Set THRESH rx=4 and CONTROL ie_rx=1. Push 3 bytes -> av_irq=0. Push a 4th -> av_irq=1 one cycle later. Read DATA once -> av_irq deasserts.
- RX_DROP=1, RX full: rx_valid with rx_data=0x55 -> byte dropped, roverflow=1, rx_used=64. Simultaneous TX pop and DATA write at count 5 -> count stays 5.

Source files
------------

// File: rtl/avmm_byte_channel.sv
// avmm_byte_channel
//   Avalon-MM slave (4 words) bridging the CPU bus to a byte-stream link.
//   TX FIFO carries CPU writes out to the link; RX FIFO buffers link bytes
//   for the CPU. Interrupt thresholds, sticky overflow flags, per-FIFO flush,
//   and optional drop-on-full RX mode.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   av_address[1:0]       0 DATA, 1 CONTROL, 2 THRESH, 3 STATUS
//   av_chipselect/read/write/writedata[31:0]
//   av_readdata[31:0]     registered read data
//   av_waitrequest        low for exactly one cycle after an accepted access
//   av_irq                registered level interrupt
//   tx_data/tx_valid/tx_ready   outbound stream (first-word fall-through)
//   rx_data/rx_valid/rx_ready   inbound stream
//
// Bus FSM
//   state  | meaning
//   S_IDLE | waitrequest high, an access is accepted here
//   S_ACK  | waitrequest low, readdata valid, master completes
module avmm_byte_channel #(
  parameter int DATA_W  = 8,
  parameter int TX_AW   = 6,
  parameter int RX_AW   = 6,
  parameter int RX_DROP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        av_address,
  input  logic              av_chipselect,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic              av_irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int TX_DEPTH  = 1 << TX_AW;
  localparam int RX_DEPTH  = 1 << RX_AW;
  localparam int TX_TH_INT = (TX_DEPTH / 8 < 1) ? 1 : TX_DEPTH / 8;
  localparam bit DROP_MODE = (RX_DROP != 0);

  localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_TH_RST   = (TX_AW+1)'(TX_TH_INT);
  localparam logic [RX_AW:0]   RX_TH_RST   = (RX_AW+1)'(1);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW+1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW+1)'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);

  typedef enum logic {S_IDLE, S_ACK} bus_state_e;

  bus_state_e state_q, state_d;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_q, tx_rd_q;
  logic [RX_AW-1:0]  rx_wr_q, rx_rd_q;
  logic [TX_AW:0]    tx_cnt_q, tx_cnt_d, tx_thresh_q;
  logic [RX_AW:0]    rx_cnt_q, rx_cnt_d, rx_thresh_q, rx_cnt_after;
  logic              ie_rx_q, ie_tx_q, wov_q, wov_d, rov_q, rov_d, irq_q;
  logic [31:0]       rdata_q, rdata_d;

  logic accept, wr_acc, rd_acc, data_wr, data_rd, ctrl_wr, thr_wr;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_flush;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_flush, rx_drop_evt;
  logic ip_rx, ip_tx;
  logic unused_wdata;

  assign unused_wdata = ^av_writedata;

  // ---------------- bus handshake FSM ----------------
  assign accept = av_chipselect & (av_read | av_write) & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    av_waitrequest = 1'b1;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ACK;
      S_ACK: begin
        av_waitrequest = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write takes priority when both strobes are asserted.
  assign wr_acc  = accept & av_write;
  assign rd_acc  = accept & av_read & ~av_write;
  assign data_wr = wr_acc & (av_address == 2'd0);
  assign data_rd = rd_acc & (av_address == 2'd0);
  assign ctrl_wr = wr_acc & (av_address == 2'd1);
  assign thr_wr  = wr_acc & (av_address == 2'd2);

  // ---------------- TX FIFO ----------------
  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rd_q];
  assign tx_push  = data_wr & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = ctrl_wr & av_writedata[2];

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else if (tx_flush) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TX_PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_PTR_ONE;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= av_writedata[DATA_W-1:0];
  end

  // ---------------- RX FIFO ----------------
  // Full is judged on the registered count, so a same-cycle CPU pop does not
  // open room for a link push until the following cycle.
  assign rx_full     = (rx_cnt_q == RX_FULL_CNT);
  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_ready    = DROP_MODE ? 1'b1 : ~rx_full;
  assign rx_push     = rx_valid & ~rx_full;
  assign rx_drop_evt = DROP_MODE & rx_valid & rx_full;
  assign rx_pop      = data_rd & ~rx_empty;
  assign rx_flush    = ctrl_wr & av_writedata[3];

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else if (rx_flush) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RX_PTR_ONE;
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_PTR_ONE;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_data;
  end

  // ---------------- control / status ----------------
  // Overflow flags: a set in the same cycle as a clear wins.
  assign wov_d = (data_wr & tx_full) | (wov_q & ~(ctrl_wr & av_writedata[10]));
  assign rov_d = rx_drop_evt | (rov_q & ~(ctrl_wr & av_writedata[11]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_rx_q     <= 1'b0;
      ie_tx_q     <= 1'b0;
      wov_q       <= 1'b0;
      rov_q       <= 1'b0;
      rx_thresh_q <= RX_TH_RST;
      tx_thresh_q <= TX_TH_RST;
    end else begin
      wov_q <= wov_d;
      rov_q <= rov_d;
      if (ctrl_wr) begin
        ie_rx_q <= av_writedata[0];
        ie_tx_q <= av_writedata[1];
      end
      if (thr_wr) begin
        rx_thresh_q <= av_writedata[RX_AW:0];
        tx_thresh_q <= av_writedata[16+TX_AW:16];
      end
    end
  end

  assign ip_rx = ie_rx_q & (rx_cnt_q >= rx_thresh_q) & (rx_cnt_q != '0);
  assign ip_tx = ie_tx_q & (tx_cnt_q <= tx_thresh_q);

  assign rx_cnt_after = rx_pop ? (rx_cnt_q - RX_CNT_ONE) : rx_cnt_q;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = '0;
      case (av_address)
        2'd0: begin
          rdata_d[DATA_W-1:0] = rx_empty ? '0 : rx_mem[rx_rd_q];
          rdata_d[15]         = ~rx_empty;
          rdata_d[31:16]      = 16'(rx_cnt_after);
        end
        2'd1: begin
          rdata_d[0]     = ie_rx_q;
          rdata_d[1]     = ie_tx_q;
          rdata_d[8]     = ip_rx;
          rdata_d[9]     = ip_tx;
          rdata_d[10]    = wov_q;
          rdata_d[11]    = rov_q;
          rdata_d[31:16] = 16'(TX_FULL_CNT - tx_cnt_q);
        end
        2'd2: rdata_d = {16'(tx_thresh_q), 16'(rx_thresh_q)};
        default: rdata_d = {16'(tx_cnt_q), 16'(rx_cnt_q)};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= ip_rx | ip_tx;
    end
  end

  assign av_readdata = rdata_q;
  assign av_irq      = irq_q;

endmodule

// File: tb/tb_avmm_byte_channel.sv
module tb_avmm_byte_channel;

  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr  [2];
  logic        cs    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        wreq  [2];
  logic        irq   [2];
  logic [7:0]  txd   [2];
  logic        txv   [2];
  logic        txr   [2];
  logic [7:0]  rxd   [2];
  logic        rxv   [2];
  logic        rxrdy [2];

  exp_t       rq0[$], rq1[$];
  logic [7:0] tq0[$], tq1[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avmm_byte_channel #(.DATA_W(8), .TX_AW(6), .RX_AW(6), .RX_DROP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .av_address(addr[0]), .av_chipselect(cs[0]),
    .av_read(rd[0]), .av_write(wr[0]), .av_writedata(wdata[0]),
    .av_readdata(rdata[0]), .av_waitrequest(wreq[0]), .av_irq(irq[0]),
    .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
    .rx_data(rxd[0]), .rx_valid(rxv[0]), .rx_ready(rxrdy[0]));

  avmm_byte_channel #(.DATA_W(8), .TX_AW(6), .RX_AW(6), .RX_DROP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .av_address(addr[1]), .av_chipselect(cs[1]),
    .av_read(rd[1]), .av_write(wr[1]), .av_writedata(wdata[1]),
    .av_readdata(rdata[1]), .av_waitrequest(wreq[1]), .av_irq(irq[1]),
    .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
    .rx_data(rxd[1]), .rx_valid(rxv[1]), .rx_ready(rxrdy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: master holds read through the completion cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cs[0] && rd[0] && !wr[0] && !wreq[0]) begin
      if (rq0.size() == 0) chk("dut0_unexpected_read", rdata[0], 32'hDEADBEEF);
      else begin e = rq0.pop_front(); chk(e.name, rdata[0], e.v); end
    end
    if (rst_n && cs[1] && rd[1] && !wr[1] && !wreq[1]) begin
      if (rq1.size() == 0) chk("dut1_unexpected_read", rdata[1], 32'hDEADBEEF);
      else begin e = rq1.pop_front(); chk(e.name, rdata[1], e.v); end
    end
  end

  // TX stream monitor: a beat transfers at the next edge when valid & ready.
  always @(negedge clk) begin
    logic [7:0] b;
    if (rst_n && txv[0] && txr[0]) begin
      if (tq0.size() == 0) chk("dut0_unexpected_tx", {24'h0, txd[0]}, 32'hFFFFFFFF);
      else begin b = tq0.pop_front(); chk("dut0_tx_byte", {24'h0, txd[0]}, {24'h0, b}); end
    end
    if (rst_n && txv[1] && txr[1]) begin
      if (tq1.size() == 0) chk("dut1_unexpected_tx", {24'h0, txd[1]}, 32'hFFFFFFFF);
      else begin b = tq1.pop_front(); chk("dut1_tx_byte", {24'h0, txd[1]}, {24'h0, b}); end
    end
  end

  task automatic bus_xfer(input int d, input logic w, input logic [1:0] a,
                          input logic [31:0] wd, input logic pop_tx,
                          input logic [31:0] exp, input string name);
    exp_t e;
    bit ok;
    if (!w) begin
      e.name = name; e.v = exp;
      if (d == 0) rq0.push_back(e); else rq1.push_back(e);
    end
    cs[d] = 1'b1; rd[d] = ~w; wr[d] = w; addr[d] = a; wdata[d] = wd;
    if (pop_tx) txr[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pop_tx) txr[d] = 1'b0;
      if (!wreq[d]) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_bus_timeout"}, 32'h0, 32'h1);
    @(posedge clk); #1;
    cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic bus_rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_xfer(d, 1'b0, a, 32'h0, 1'b0, exp, name);
  endtask

  task automatic bus_wr(input int d, input logic [1:0] a, input logic [31:0] wd);
    bus_xfer(d, 1'b1, a, wd, 1'b0, 32'h0, "wr");
  endtask

  task automatic rx_send(input int d, input logic [7:0] b);
    bit ok;
    rxv[d] = 1'b1; rxd[d] = b; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rxrdy[d]) begin
        @(posedge clk); #1; ok = 1'b1; break;
      end
      @(posedge clk); #1;
    end
    rxv[d] = 1'b0;
    if (!ok) chk("rx_send_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; cs[d] = 0; rd[d] = 0; wr[d] = 0; wdata[d] = '0;
      txr[d] = 0; rxd[d] = '0; rxv[d] = 0;
    end
    repeat (3) @(posedge clk); #1;

    // reset state
    chk("rst_waitreq", {31'h0, wreq[0]}, 32'h1);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_irq", {31'h0, irq[0]}, 32'h0);
    chk("rst_tx_valid", {31'h0, txv[0]}, 32'h0);
    chk("rst_rx_ready", {31'h0, rxrdy[0]}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rd(0, 2'd3, 32'h00000000, "rst_status");
    bus_rd(0, 2'd1, 32'h00400000, "rst_control");
    bus_rd(0, 2'd2, 32'h00080001, "rst_thresh");
    bus_rd(1, 2'd3, 32'h00000000, "rst_status_dut1");

    // TX basic path
    bus_wr(0, 2'd0, 32'h41);
    bus_wr(0, 2'd0, 32'h42);
    chk("tx_valid_after_wr", {31'h0, txv[0]}, 32'h1);
    chk("tx_head", {24'h0, txd[0]}, 32'h41);
    bus_rd(0, 2'd3, 32'h00020000, "status_tx2");
    tq0.push_back(8'h41); tq0.push_back(8'h42);
    txr[0] = 1'b1;
    repeat (2) @(posedge clk); #1;
    txr[0] = 1'b0;
    chk("tx_drained", {31'h0, txv[0]}, 32'h0);

    // TX overflow
    for (int i = 0; i < 65; i++) bus_wr(0, 2'd0, 32'(i));
    bus_rd(0, 2'd1, 32'h00000400, "ctrl_woverflow");
    bus_wr(0, 2'd1, 32'h400);
    bus_rd(0, 2'd1, 32'h00000000, "ctrl_wov_cleared");
    bus_wr(0, 2'd1, 32'h4);
    bus_rd(0, 2'd3, 32'h00000000, "status_tx_flushed");
    bus_rd(0, 2'd1, 32'h00400000, "ctrl_after_flush");

    // RX back-pressure
    for (int i = 0; i < 64; i++) rx_send(0, 8'(8'h80 + i));
    chk("rx_ready_full", {31'h0, rxrdy[0]}, 32'h0);
    rxv[0] = 1'b1; rxd[0] = 8'hC0;
    bus_rd(0, 2'd0, 32'h003F8080, "rx_pop_full");
    rxv[0] = 1'b0;
    chk("rx_ready_refull", {31'h0, rxrdy[0]}, 32'h0);
    bus_rd(0, 2'd3, 32'h00000040, "status_rx64");
    bus_rd(0, 2'd0, 32'h003F8081, "rx_pop2");
    bus_wr(0, 2'd1, 32'h8);
    bus_rd(0, 2'd3, 32'h00000000, "status_rx_flushed");

    // RX threshold interrupt
    bus_wr(0, 2'd2, 32'h00080004);
    bus_rd(0, 2'd2, 32'h00080004, "thresh_rb");
    bus_wr(0, 2'd1, 32'h1);
    rx_send(0, 8'h11); rx_send(0, 8'h12); rx_send(0, 8'h13);
    @(posedge clk); #1;
    chk("irq_below_thresh", {31'h0, irq[0]}, 32'h0);
    rx_send(0, 8'h14);
    chk("irq_not_yet", {31'h0, irq[0]}, 32'h0);
    @(posedge clk); #1;
    chk("irq_asserted", {31'h0, irq[0]}, 32'h1);
    bus_rd(0, 2'd1, 32'h00400101, "ctrl_ip_rx");
    bus_rd(0, 2'd0, 32'h00038011, "rx_pop_irq");
    chk("irq_deasserted", {31'h0, irq[0]}, 32'h0);

    // RX drop mode
    for (int i = 0; i < 64; i++) rx_send(1, 8'(i));
    chk("drop_rx_ready", {31'h0, rxrdy[1]}, 32'h1);
    rx_send(1, 8'h55);
    bus_rd(1, 2'd3, 32'h00000040, "drop_status");
    bus_rd(1, 2'd1, 32'h00400800, "drop_roverflow");
    bus_rd(1, 2'd0, 32'h003F8000, "drop_head");

    // simultaneous TX push and pop at count 5
    for (int i = 0; i < 5; i++) bus_wr(1, 2'd0, 32'(8'hA0 + i));
    bus_rd(1, 2'd3, 32'h0005003F, "status_tx5");
    tq1.push_back(8'hA0);
    bus_xfer(1, 1'b1, 2'd0, 32'hA5, 1'b1, 32'h0, "wr_pop");
    bus_rd(1, 2'd3, 32'h0005003F, "status_pushpop");
    chk("tx_head_after_pop", {24'h0, txd[1]}, 32'hA1);
    bus_wr(1, 2'd1, 32'h800);
    bus_rd(1, 2'd1, 32'h003B0000, "ctrl_rov_cleared");

    // asynchronous reset with data held
    rst_n = 1'b0; #1;
    chk("async_rst_tx_valid", {31'h0, txv[1]}, 32'h0);
    chk("async_rst_rdata", rdata[1], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rd(1, 2'd3, 32'h00000000, "status_after_reset");

    repeat (2) @(posedge clk); #1;
    chk("queues_drained", 32'(rq0.size() + rq1.size() + tq0.size() + tq1.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
